// File: rtl/spi_slave_byte_pkg.sv
// Shared types and defaults for the SPI mode-0 byte responder.
package spi_slave_byte_pkg;

  localparam int         DW_DEF   = 8;
  localparam int         SYNC_DEF = 2;
  localparam logic [7:0] FILL_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_slave_byte_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, with 1-clk rise/fall strobes
// taken from the synchronised level and one extra edge-detect flop.
module spi_slave_byte_sync_edge
  import spi_slave_byte_pkg::*;
#(
  parameter int   STAGES    = SYNC_DEF,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_byte.sv
// SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) oversampled in the clk domain.
// Optional macro SPI_SLV_TRISTATE_EN adds miso_oe_o and forces miso low outside a frame.
module spi_slave_byte
  import spi_slave_byte_pkg::*;
#(
  parameter int          DW          = DW_DEF,
  parameter int          SYNC_STAGES = SYNC_DEF,
  parameter logic [DW-1:0] FILL      = DW'(FILL_DEF)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          cs_i,
  input  logic          sck_i,
  input  logic          mosi_i,
  output logic          miso_o,
  input  logic [DW-1:0] tx_data_i,
  input  logic          tx_valid_i,
  output logic          tx_ready_o,
  output logic [DW-1:0] rx_data_o,
  output logic          rx_valid_o,
  output logic          busy_o,
  output logic          frm_err_o,
  output logic          tx_underrun_o
`ifdef SPI_SLV_TRISTATE_EN
  ,
  output logic          miso_oe_o
`endif
);

  localparam int CW = (DW > 2) ? $clog2(DW) : 1;

  logic csLevel, csRise, csFall;
  logic sckRise, sckFall, unusedSckLevel;
  logic mosiS, unusedMosiRise, unusedMosiFall;

  spi_slave_byte_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uCsSync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (cs_i),
    .level_o (csLevel),
    .rise_o  (csRise),
    .fall_o  (csFall)
  );

  spi_slave_byte_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uSckSync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (sck_i),
    .level_o (unusedSckLevel),
    .rise_o  (sckRise),
    .fall_o  (sckFall)
  );

  spi_slave_byte_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) uMosiSync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (mosi_i),
    .level_o (mosiS),
    .rise_o  (unusedMosiRise),
    .fall_o  (unusedMosiFall)
  );

  state_e        state_q;
  logic [DW-1:0] txSh_q;
  logic [DW-1:0] rxSh_q;
  logic [DW-1:0] rxData_q;
  logic [CW-1:0] bitCnt_q;
  logic          reload_q;
  logic          rxPend_q;
  logic          rxValid_q;
  logic          txReady_q;
  logic          txUnderrun_q;
  logic          frmErr_q;
  logic [DW-1:0] loadVal_d;
  logic [DW-1:0] rxByte_d;

  assign loadVal_d = tx_valid_i ? tx_data_i : FILL;
  assign rxByte_d  = {rxSh_q[DW-2:0], mosiS};

  // cs_rise outranks any sck strobe in the same clk; rx_valid trails rx_data by one clk.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      txSh_q       <= FILL;
      rxSh_q       <= '0;
      rxData_q     <= '0;
      bitCnt_q     <= '0;
      reload_q     <= 1'b0;
      rxPend_q     <= 1'b0;
      rxValid_q    <= 1'b0;
      txReady_q    <= 1'b0;
      txUnderrun_q <= 1'b0;
      frmErr_q     <= 1'b0;
    end else begin
      txReady_q    <= 1'b0;
      txUnderrun_q <= 1'b0;
      frmErr_q     <= 1'b0;
      rxPend_q     <= 1'b0;
      rxValid_q    <= rxPend_q;
      case (state_q)
        IDLE: begin
          if (csFall) state_q <= LOAD;
        end
        LOAD: begin
          if (csRise) begin
            state_q <= IDLE;
          end else begin
            txSh_q       <= loadVal_d;
            txReady_q    <= tx_valid_i;
            txUnderrun_q <= ~tx_valid_i;
            bitCnt_q     <= '0;
            reload_q     <= 1'b0;
            state_q      <= SHIFT;
          end
        end
        SHIFT: begin
          if (csRise) begin
            state_q  <= IDLE;
            reload_q <= 1'b0;
            bitCnt_q <= '0;
            if (bitCnt_q != '0) frmErr_q <= 1'b1;
          end else begin
            if (sckRise) begin
              rxSh_q <= rxByte_d;
              if (bitCnt_q == CW'(DW-1)) begin
                rxData_q <= rxByte_d;
                rxPend_q <= 1'b1;
                bitCnt_q <= '0;
                reload_q <= 1'b1;
              end else begin
                bitCnt_q <= bitCnt_q + 1'b1;
              end
            end
            if (sckFall) begin
              if (reload_q) begin
                txSh_q       <= loadVal_d;
                txReady_q    <= tx_valid_i;
                txUnderrun_q <= ~tx_valid_i;
                reload_q     <= 1'b0;
              end else begin
                txSh_q <= {txSh_q[DW-2:0], 1'b0};
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = ~csLevel;
  assign rx_data_o     = rxData_q;
  assign rx_valid_o    = rxValid_q;
  assign tx_ready_o    = txReady_q;
  assign tx_underrun_o = txUnderrun_q;
  assign frm_err_o     = frmErr_q;

`ifdef SPI_SLV_TRISTATE_EN
  assign miso_o    = busy_o ? txSh_q[DW-1] : 1'b0;
  assign miso_oe_o = busy_o;
`else
  assign miso_o    = txSh_q[DW-1];
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// Directed bench for spi_slave_byte: a behavioural mode-0 master at sck = clk/20.
module tb_spi_slave_byte;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs, sck, mosi, miso;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, frm_err, tx_underrun;
`ifdef SPI_SLV_TRISTATE_EN
  logic       miso_oe;
  localparam logic IDLE_MISO = 1'b0;
`else
  localparam logic IDLE_MISO = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int rxValidCnt = 0, txReadyCnt = 0, underrunCnt = 0, frmErrCnt = 0;
  int rv0, tr0, ur0, fe0;
  int lat;
  logic [7:0] m0, m1, m2;

  spi_slave_byte dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .cs_i          (cs),
    .sck_i         (sck),
    .mosi_i        (mosi),
    .miso_o        (miso),
    .tx_data_i     (tx_data),
    .tx_valid_i    (tx_valid),
    .tx_ready_o    (tx_ready),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .busy_o        (busy),
    .frm_err_o     (frm_err),
    .tx_underrun_o (tx_underrun)
`ifdef SPI_SLV_TRISTATE_EN
    ,
    .miso_oe_o     (miso_oe)
`endif
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rx_valid)    rxValidCnt  <= rxValidCnt + 1;
    if (tx_ready)    txReadyCnt  <= txReadyCnt + 1;
    if (tx_underrun) underrunCnt <= underrunCnt + 1;
    if (frm_err)     frmErrCnt   <= frmErrCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    rv0 = rxValidCnt; tr0 = txReadyCnt; ur0 = underrunCnt; fe0 = frmErrCnt;
  endtask

  task automatic startFrame();
    cs = 1'b0;
    waitClk(10);
  endtask

  // Shifts nBits of b MSB first; on the last byte cs rises together with the final sck fall.
  task automatic applyStimulus(input logic [7:0] b, input int nBits, input bit lastByte,
                               output logic [7:0] m);
    m   = 8'h00;
    lat = 0;
    for (int i = 0; i < nBits; i++) begin
      mosi = b[7-i];
      waitClk(10);
      m[7-i] = miso;
      sck = 1'b1;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (rx_valid && lat == 0) lat = k;
      end
      sck = 1'b0;
      if (lastByte && i == nBits - 1) cs = 1'b1;
    end
    if (lastByte) waitClk(10);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    waitClk(3);
    checkOutput("rst_miso", miso, IDLE_MISO);
    checkOutput("rst_tx_ready", tx_ready, 0);
    checkOutput("rst_rx_data", rx_data, 0);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frm_err", frm_err, 0);
    checkOutput("rst_tx_underrun", tx_underrun, 0);
    rst_n = 1'b1;
    waitClk(5);

    $display("[TB] single byte A5 / tx 3C");
    snap();
    tx_data = 8'h3C; tx_valid = 1'b1;
    startFrame();
    checkOutput("busy_in_frame", busy, 1);
    applyStimulus(8'hA5, 8, 1'b1, m0);
    checkOutput("a5_miso", m0, 8'h3C);
    checkOutput("a5_rx_data", rx_data, 8'hA5);
    checkOutput("a5_rx_valid_cnt", rxValidCnt - rv0, 1);
    checkOutput("a5_tx_ready_cnt", txReadyCnt - tr0, 1);
    checkOutput("a5_underrun_cnt", underrunCnt - ur0, 0);
    checkOutput("a5_rx_latency", lat, 4);
    checkOutput("a5_busy_after", busy, 0);
    checkOutput("a5_frm_err_cnt", frmErrCnt - fe0, 0);

    $display("[TB] partial frame, 5 bits of F0");
    snap();
    tx_data = 8'h55;
    startFrame();
    applyStimulus(8'hF0, 5, 1'b0, m0);
    waitClk(10);
    cs = 1'b1;
    waitClk(10);
    checkOutput("part_miso", m0, 8'h50);
    checkOutput("part_frm_err_cnt", frmErrCnt - fe0, 1);
    checkOutput("part_rx_valid_cnt", rxValidCnt - rv0, 0);
    checkOutput("part_rx_data", rx_data, 8'hA5);

    $display("[TB] three byte frame 11/22/33, tx 81/42/24");
    snap();
    tx_data = 8'h81;
    startFrame();
    tx_data = 8'h42;
    applyStimulus(8'h11, 8, 1'b0, m0);
    checkOutput("f3_rx0", rx_data, 8'h11);
    waitClk(5);
    tx_data = 8'h24;
    applyStimulus(8'h22, 8, 1'b0, m1);
    checkOutput("f3_rx1", rx_data, 8'h22);
    applyStimulus(8'h33, 8, 1'b1, m2);
    checkOutput("f3_rx2", rx_data, 8'h33);
    checkOutput("f3_miso0", m0, 8'h81);
    checkOutput("f3_miso1", m1, 8'h42);
    checkOutput("f3_miso2", m2, 8'h24);
    checkOutput("f3_rx_valid_cnt", rxValidCnt - rv0, 3);
    checkOutput("f3_tx_ready_cnt", txReadyCnt - tr0, 3);
    checkOutput("f3_frm_err_cnt", frmErrCnt - fe0, 0);

    $display("[TB] underrun frame, tx_valid low");
    snap();
    tx_valid = 1'b0; tx_data = 8'hAA;
    startFrame();
    applyStimulus(8'h12, 8, 1'b0, m0);
    waitClk(5);
    applyStimulus(8'h34, 8, 1'b1, m1);
    checkOutput("ur_miso0", m0, 8'hFF);
    checkOutput("ur_miso1", m1, 8'hFF);
    checkOutput("ur_underrun_cnt", underrunCnt - ur0, 2);
    checkOutput("ur_tx_ready_cnt", txReadyCnt - tr0, 0);
    checkOutput("ur_rx_data", rx_data, 8'h34);
    checkOutput("ur_rx_valid_cnt", rxValidCnt - rv0, 2);

    $display("[TB] reset in the middle of a byte");
    tx_valid = 1'b1; tx_data = 8'h0F;
    startFrame();
    applyStimulus(8'hC3, 3, 1'b0, m0);
    rst_n = 1'b0;
    waitClk(2);
    checkOutput("mrst_rx_data", rx_data, 0);
    checkOutput("mrst_rx_valid", rx_valid, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_miso", miso, IDLE_MISO);
    checkOutput("mrst_tx_ready", tx_ready, 0);
    checkOutput("mrst_frm_err", frm_err, 0);
    checkOutput("mrst_tx_underrun", tx_underrun, 0);
    cs = 1'b1; sck = 1'b0;
    waitClk(2);
    rst_n = 1'b1;
    waitClk(5);
    snap();
    tx_data = 8'h96;
    startFrame();
    applyStimulus(8'h5A, 8, 1'b1, m0);
    checkOutput("post_rst_rx_data", rx_data, 8'h5A);
    checkOutput("post_rst_miso", m0, 8'h96);
    checkOutput("post_rst_rx_valid_cnt", rxValidCnt - rv0, 1);
    checkOutput("post_rst_frm_err_cnt", frmErrCnt - fe0, 0);

    $display("[TB] sck toggling with cs high");
    snap();
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      sck = 1'b1;
      waitClk(10);
      sck = 1'b0;
      waitClk(10);
    end
    checkOutput("idle_rx_valid_cnt", rxValidCnt - rv0, 0);
    checkOutput("idle_tx_ready_cnt", txReadyCnt - tr0, 0);
    checkOutput("idle_underrun_cnt", underrunCnt - ur0, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_rx_data", rx_data, 8'h5A);
`ifdef SPI_SLV_TRISTATE_EN
    checkOutput("idle_miso_oe", miso_oe, 0);
    checkOutput("idle_miso", miso, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
